// File: rtl/shift_cmd_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_cmd_sched_if : command push bus into the Shift_Head scheduler      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface shift_cmd_sched_if #(
  parameter int HEAD_SHIFT_WIDTH = 4,
  parameter int META_SHIFT_WIDTH = 4,
  parameter int KW               = 8
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [HEAD_SHIFT_WIDTH-1:0] cmd_headShift;
  logic [META_SHIFT_WIDTH-1:0] cmd_metaShift;
  logic [KW-1:0]               cmd_extField;

  modport master (
    output cmd_valid, cmd_headShift, cmd_metaShift, cmd_extField,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_headShift, cmd_metaShift, cmd_extField,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/shift_cmd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_cmd_sched : per-packet shift command FIFO/scheduler for Shift_Head |
// | Option macro: SHIFT_CMD_SCHED_STAT_EN (packet/error counters)   Rev 1.0  |
// +--------------------------------------------------------------------------+
module shift_cmd_sched #(
  parameter int CMD_DEPTH        = 4,
  parameter int CMD_AW           = 2,
  parameter int HEAD_SHIFT_WIDTH = 4,
  parameter int META_SHIFT_WIDTH = 4,
  parameter int HEAD_CANDI_NUM   = 8,
  parameter int TAG_WIDTH        = 3,
  parameter int TAG_VALID_BIT    = 0,
  parameter int TAG_START_BIT    = 1,
  parameter int TAG_TAIL_BIT     = 2,
  parameter int KEY_FILED_NUM    = 2,
  parameter int KEY_FIELD_WIDTH  = 4,
  parameter int KW               = KEY_FILED_NUM * KEY_FIELD_WIDTH
) (
  input  wire                         i_clk,
  input  wire                         i_rst_n,
  shift_cmd_sched_if.slave            cmd_if,
  input  wire  [TAG_WIDTH-1:0]        i_headTag,
  output logic [HEAD_SHIFT_WIDTH-1:0] o_headShift,
  output logic [META_SHIFT_WIDTH-1:0] o_metaShift,
  output logic [KW-1:0]               o_extField,
  output logic                        o_underflow,
  output logic                        o_protoErr,
  output logic                        o_rangeErr
`ifdef SHIFT_CMD_SCHED_STAT_EN
  ,
  output logic [31:0]                 o_pktCnt,
  output logic [15:0]                 o_errCnt
`endif
);

  localparam logic [CMD_AW:0]           c_depth  = (CMD_AW+1)'(CMD_DEPTH);
  localparam logic [HEAD_SHIFT_WIDTH-1:0] c_hs_max = HEAD_SHIFT_WIDTH'(HEAD_CANDI_NUM - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_PKT = 1'b1} state_t;

  state_t                      r_state;
  logic [CMD_AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CMD_AW:0]             r_count, w_count_nxt;
  logic                        r_cmd_ready;
  logic [HEAD_SHIFT_WIDTH-1:0] r_mem_hs [CMD_DEPTH];
  logic [META_SHIFT_WIDTH-1:0] r_mem_ms [CMD_DEPTH];
  logic [KW-1:0]               r_mem_ef [CMD_DEPTH];
  logic [HEAD_SHIFT_WIDTH-1:0] r_hold_hs;
  logic [META_SHIFT_WIDTH-1:0] r_hold_ms;
  logic [KW-1:0]               r_hold_ef;

  logic                        w_sop, w_eop, w_empty, w_push, w_pop, w_hs_over;
  logic [HEAD_SHIFT_WIDTH-1:0] w_head_hs;
  logic [META_SHIFT_WIDTH-1:0] w_head_ms;
  logic [KW-1:0]               w_head_ef;

  assign w_sop   = i_headTag[TAG_START_BIT] & i_headTag[TAG_VALID_BIT];
  assign w_eop   = i_headTag[TAG_TAIL_BIT]  & i_headTag[TAG_VALID_BIT];
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_if.cmd_valid & r_cmd_ready;
  assign w_pop   = w_sop & ~w_empty;
  assign cmd_if.cmd_ready = r_cmd_ready;

  // FIFO head as seen by a starting packet: zeros when empty, headShift clamped
  always_comb begin
    w_hs_over = 1'b0;
    w_head_hs = '0;
    w_head_ms = '0;
    w_head_ef = '0;
    if (!w_empty) begin
      w_hs_over = (r_mem_hs[r_rd_ptr] > c_hs_max);
      w_head_hs = w_hs_over ? c_hs_max : r_mem_hs[r_rd_ptr];
      w_head_ms = r_mem_ms[r_rd_ptr];
      w_head_ef = r_mem_ef[r_rd_ptr];
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    o_headShift = (r_state == S_IDLE) ? w_head_hs : r_hold_hs;
    o_metaShift = (r_state == S_IDLE) ? w_head_ms : r_hold_ms;
    o_extField  = (r_state == S_IDLE) ? w_head_ef : r_hold_ef;
    o_underflow = w_sop & w_empty;
    o_protoErr  = w_sop & (r_state == S_PKT);
    o_rangeErr  = w_pop & w_hs_over;
  end

  // Storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_hs[r_wr_ptr] <= cmd_if.cmd_headShift;
      r_mem_ms[r_wr_ptr] <= cmd_if.cmd_metaShift;
      r_mem_ef[r_wr_ptr] <= cmd_if.cmd_extField;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
      r_hold_hs   <= '0;
      r_hold_ms   <= '0;
      r_hold_ef   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != c_depth);
      if (w_sop) begin
        r_hold_hs <= w_head_hs;
        r_hold_ms <= w_head_ms;
        r_hold_ef <= w_head_ef;
      end
      unique case (r_state)
        S_IDLE:  if (w_sop && !w_eop) r_state <= S_PKT;
        S_PKT:   if (w_eop) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SHIFT_CMD_SCHED_STAT_EN
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_sop && (r_pkt_cnt != '1)) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if ((o_underflow | o_protoErr | o_rangeErr) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_pktCnt = r_pkt_cnt;
  assign o_errCnt = r_err_cnt;
`endif

endmodule
`default_nettype wire
